sweep_scheduler: RTL and testbench

Sequencer for the synchronous diagnostic sweep of the ASIC test chip. On a start request it walks `mux_decoder_input` over every combinational path. For each path it:
- holds the ASIC in reset for a fixed interval;
- sweeps `K` over its full range;
- samples `comparison_result` to build a per-path pass/fail map and a failure count.

It sits in the FPGA tester beside the directed mux/FF tests, owns the ASIC configuration outputs while busy, and reports back through a start/done handshake.

---
 rtl/sweep_scheduler_pkg.sv | 22 ++
 rtl/sweep_window_checker.sv | 34 +++
 rtl/sweep_scheduler.sv | 175 +++++++++++++++++
 tb/tb_sweep_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_scheduler_pkg.sv
// Shared definitions for the ASIC diagnostic sweep: state encoding,
// static config codes and default sweep geometry.
package sweep_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_HOLD = 3'd1,
        ST_SWEEP    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_NEXT     = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam int          PATH_W            = 5;
    localparam logic [2:0]  BIST_IDLE_CODE    = 3'd6;

    localparam int          DEF_NUM_PATHS     = 21;
    localparam int          DEF_RESET_CYCLES  = 100;
    localparam int          DEF_K_WIDTH       = 6;
    localparam int          DEF_CHECK_LAT     = 1;

endpackage

// File: rtl/sweep_window_checker.sv
// Delays the sweep-active level by CHECK_LAT cycles to form the sample window.
// Latency: CHECK_LAT cycles; no backpressure, mismatch is combinational on the input.
module sweep_window_checker #(
    parameter int CHECK_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic sweep_active,
    input  logic comparison_result,
    output logic sample_en,
    output logic mismatch
);

    generate
        if (CHECK_LAT == 0) begin : g_nodly
            assign sample_en = sweep_active;
        end else begin : g_dly
            logic [CHECK_LAT-1:0] dly;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    dly <= '0;
                end else begin
                    dly <= (dly << 1) | CHECK_LAT'(sweep_active);
                end
            end

            assign sample_en = dly[CHECK_LAT-1];
        end
    endgenerate

    assign mismatch = sample_en & ~comparison_result;

endmodule

// File: rtl/sweep_scheduler.sv
// Walks every decoder path: reset hold, full K sweep, latency-aligned pass/fail capture.
// Latency: RESET_CYCLES + 2^K_WIDTH + CHECK_LAT + 1 cycles per path; no backpressure, abort wins.
module sweep_scheduler
    import sweep_scheduler_pkg::*;
#(
    parameter int NUM_PATHS    = DEF_NUM_PATHS,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int K_WIDTH      = DEF_K_WIDTH,
    parameter int CHECK_LAT    = DEF_CHECK_LAT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 comparison_result,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 rst_c,
    output logic [K_WIDTH-1:0]   K,
    output logic [PATH_W-1:0]    mux_decoder_input,
    output logic                 clock_mux_sel,
    output logic                 mode_mux_sel,
    output logic                 sel_chain_input,
    output logic                 sel_chain_output,
    output logic [2:0]           bist_decoder_input,
    output logic [NUM_PATHS-1:0] path_fail,
    output logic [PATH_W-1:0]    fail_count,
    output logic                 error_flag
);

    localparam int CNT_W = $clog2(RESET_CYCLES + CHECK_LAT + 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               abort_take;
    logic               sample_en;
    logic               mismatch;
    logic               record;

    sweep_window_checker #(
        .CHECK_LAT (CHECK_LAT)
    ) u_window (
        .clock             (clock),
        .reset             (reset),
        .sweep_active      (state == ST_SWEEP),
        .comparison_result (comparison_result),
        .sample_en         (sample_en),
        .mismatch          (mismatch)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        abort_take = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = ST_RST_HOLD;
                end
            end
            ST_RST_HOLD: begin
                if (cnt == CNT_W'(RESET_CYCLES - 1)) state_nxt = ST_SWEEP;
            end
            ST_SWEEP: begin
                if (K == '1) state_nxt = (CHECK_LAT > 0) ? ST_DRAIN : ST_NEXT;
            end
            ST_DRAIN: begin
                if (cnt == CNT_W'(CHECK_LAT - 1)) state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                state_nxt = (mux_decoder_input == PATH_W'(NUM_PATHS - 1)) ? ST_DONE : ST_RST_HOLD;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (abort && state != ST_IDLE) begin
            abort_take = 1'b1;
            state_nxt  = ST_IDLE;
        end
    end

    // Dwell counter restarts on every state change.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // K runs 0..max in SWEEP and parks at max through DRAIN/NEXT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            K <= '0;
        end else begin
            case (state_nxt)
                ST_SWEEP:          K <= (state == ST_SWEEP) ? K + 1'b1 : '0;
                ST_DRAIN, ST_NEXT: K <= K;
                default:           K <= '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mux_decoder_input <= '0;
        end else if (accept) begin
            mux_decoder_input <= '0;
        end else if (state == ST_NEXT && state_nxt == ST_RST_HOLD) begin
            mux_decoder_input <= mux_decoder_input + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy               <= 1'b0;
            done               <= 1'b0;
            aborted            <= 1'b0;
            rst_c              <= 1'b1;
            sel_chain_output   <= 1'b1;
            clock_mux_sel      <= 1'b0;
            mode_mux_sel       <= 1'b0;
            sel_chain_input    <= 1'b0;
            bist_decoder_input <= BIST_IDLE_CODE;
        end else begin
            busy               <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
            done               <= (state_nxt == ST_DONE);
            aborted            <= abort_take;
            rst_c              <= !((state_nxt == ST_SWEEP) || (state_nxt == ST_DRAIN) ||
                                    (state_nxt == ST_NEXT));
            sel_chain_output   <= (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
            clock_mux_sel      <= 1'b0;
            mode_mux_sel       <= 1'b0;
            sel_chain_input    <= 1'b0;
            bist_decoder_input <= BIST_IDLE_CODE;
        end
    end

    // A sample taken in the abort cycle is still inside SWEEP/DRAIN, so it is kept.
    assign record = mismatch && ((state == ST_SWEEP) || (state == ST_DRAIN));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            path_fail  <= '0;
            fail_count <= '0;
            error_flag <= 1'b0;
        end else if (accept) begin
            path_fail  <= '0;
            fail_count <= '0;
            error_flag <= 1'b0;
        end else if (record && !path_fail[mux_decoder_input]) begin
            path_fail[mux_decoder_input] <= 1'b1;
            fail_count                   <= fail_count + 1'b1;
            error_flag                   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sweep_scheduler.sv
// Scoreboarded bench for sweep_scheduler: an ASIC compare model drives
// comparison_result from K/path with CHECK_LAT alignment.
module tb_sweep_scheduler;

    localparam int NP       = 21;
    localparam int RC       = 100;
    localparam int KW       = 6;
    localparam int CL       = 1;
    localparam int PER_PATH = RC + (1 << KW) + CL + 1;
    localparam int DONE_AT  = NP * PER_PATH + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          comparison_result = 1'b1;
    logic          busy, done, aborted, rst_c;
    logic [KW-1:0] K;
    logic [4:0]    mux_decoder_input;
    logic          clock_mux_sel, mode_mux_sel, sel_chain_input, sel_chain_output;
    logic [2:0]    bist_decoder_input;
    logic [NP-1:0] path_fail;
    logic [4:0]    fail_count;
    logic          error_flag;

    sweep_scheduler #(
        .NUM_PATHS(NP), .RESET_CYCLES(RC), .K_WIDTH(KW), .CHECK_LAT(CL)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .comparison_result(comparison_result),
        .busy(busy), .done(done), .aborted(aborted), .rst_c(rst_c), .K(K),
        .mux_decoder_input(mux_decoder_input),
        .clock_mux_sel(clock_mux_sel), .mode_mux_sel(mode_mux_sel),
        .sel_chain_input(sel_chain_input), .sel_chain_output(sel_chain_output),
        .bist_decoder_input(bist_decoder_input),
        .path_fail(path_fail), .fail_count(fail_count), .error_flag(error_flag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NP-1:0] pf;
        logic [4:0]    fc;
        logic          ef;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // ASIC model state
    int            mode = 0;
    int            pt_path = 0;
    int            pt_k = 0;
    logic [NP-1:0] fail_mask = '0;
    logic [KW-1:0] prev_k = '0;
    logic [4:0]    prev_mux = '0;
    logic          prev_rstc = 1'b1;

    localparam int RV_W = 49;
    logic [RV_W-1:0] rst_vec_exp;
    logic [RV_W-1:0] rst_vec_obs;

    task automatic drive_cr();
        case (mode)
            1:       comparison_result = !(!prev_rstc && prev_mux == 5'(pt_path) && prev_k == KW'(pt_k));
            2:       comparison_result = !fail_mask[mux_decoder_input];
            3:       comparison_result = !(rst_c || K == '0);
            default: comparison_result = 1'b1;
        endcase
        prev_k    = K;
        prev_mux  = mux_decoder_input;
        prev_rstc = rst_c;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        drive_cr();
    endtask

    // Full sweep from a start pulse; optional extra start while busy.
    task automatic run_sweep(input string name, input int busy_start_at);
        int   cyc;
        int   changes;
        logic order_ok;
        logic [4:0] last_mux;
        exp_t e;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        order_ok = (mux_decoder_input == 5'd0);
        last_mux = mux_decoder_input;
        changes  = 0;
        while (done !== 1'b1 && cyc < DONE_AT + 100) begin
            start = (cyc == busy_start_at);
            step();
            cyc++;
            if (mux_decoder_input !== last_mux) begin
                if (mux_decoder_input !== last_mux + 5'd1) order_ok = 1'b0;
                last_mux = mux_decoder_input;
                changes++;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (done !== 1'b1 || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL %s done_cycle: got done=%b at cycle %0d want cycle %0d", name, done, cyc, e.cyc);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        end
        vectors++;
        if (path_fail !== e.pf || fail_count !== e.fc || error_flag !== e.ef) begin
            miscompares++;
            $display("FAIL %s results: got pf=%h fc=%0d ef=%b want pf=%h fc=%0d ef=%b",
                     name, path_fail, fail_count, error_flag, e.pf, e.fc, e.ef);
        end
        vectors++;
        if (!order_ok || changes != NP - 1) begin
            miscompares++;
            $display("FAIL %s path_order: got ok=%b changes=%0d want ok=1 changes=%0d", name, order_ok, changes, NP - 1);
        end
        step();
        vectors++;
        if (done !== 1'b0 || rst_c !== 1'b1 || sel_chain_output !== 1'b1 || K !== '0) begin
            miscompares++;
            $display("FAIL %s idle_after_done: got done=%b rst_c=%b sco=%b K=%0d want 0 1 1 0",
                     name, done, rst_c, sel_chain_output, K);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        rst_vec_obs = {busy, done, aborted, rst_c, K, mux_decoder_input, clock_mux_sel, mode_mux_sel,
                       sel_chain_input, sel_chain_output, bist_decoder_input, path_fail, fail_count, error_flag};
        vectors++;
        if (rst_vec_obs !== rst_vec_exp) begin
            miscompares++;
            $display("FAIL reset_values: got %h want %h", rst_vec_obs, rst_vec_exp);
        end
        @(negedge clock);
        reset = 1'b0;
        step();
        step();
    endtask

    task automatic test_stuck_high();
        mode = 0;
        sb.push_back('{pf: '0, fc: 5'd0, ef: 1'b0, cyc: DONE_AT});
        run_sweep("stuck_high", -1);
        vectors++;
        if (mux_decoder_input !== 5'(NP - 1)) begin
            miscompares++;
            $display("FAIL stuck_high last_path: got %0d want %0d", mux_decoder_input, NP - 1);
        end
    endtask

    task automatic test_single_point();
        mode = 1; pt_path = 5; pt_k = 17;
        sb.push_back('{pf: NP'(1) << 5, fc: 5'd1, ef: 1'b1, cyc: DONE_AT});
        run_sweep("single_point", -1);
    endtask

    task automatic test_two_paths();
        mode = 2;
        fail_mask = (NP'(1) << 3) | (NP'(1) << 20);
        sb.push_back('{pf: fail_mask, fc: 5'd2, ef: 1'b1, cyc: DONE_AT});
        run_sweep("two_paths", -1);
    endtask

    task automatic test_window_edges();
        mode = 3;
        sb.push_back('{pf: '0, fc: 5'd0, ef: 1'b0, cyc: DONE_AT});
        run_sweep("window_edges", -1);
        mode = 0;
    endtask

    task automatic test_busy_start();
        mode = 0;
        sb.push_back('{pf: '0, fc: 5'd0, ef: 1'b0, cyc: DONE_AT});
        run_sweep("busy_start", 2000);
    endtask

    task automatic test_abort();
        int   n;
        int   done_seen;
        exp_t e;
        mode = 2;
        fail_mask = NP'(1) << 2;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(mux_decoder_input == 5'd7 && rst_c == 1'b0 && K == KW'(30)) && n < DONE_AT) begin
            step();
            n++;
        end
        vectors++;
        if (n >= DONE_AT) begin
            miscompares++;
            $display("FAIL abort reach_path7: got timeout after %0d cycles want path 7 sweep", n);
        end
        abort = 1'b1;
        comparison_result = 1'b0;
        sb.push_back('{pf: (NP'(1) << 2) | (NP'(1) << 7), fc: 5'd2, ef: 1'b1, cyc: 0});
        step();
        abort = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rst_c !== 1'b1 ||
            K !== '0 || sel_chain_output !== 1'b1 || bist_decoder_input !== 3'd6) begin
            miscompares++;
            $display("FAIL abort idle_outputs: got aborted=%b busy=%b done=%b rst_c=%b K=%0d sco=%b bist=%0d want 1 0 0 1 0 1 6",
                     aborted, busy, done, rst_c, K, sel_chain_output, bist_decoder_input);
        end
        vectors++;
        if (path_fail !== e.pf || fail_count !== e.fc || error_flag !== e.ef) begin
            miscompares++;
            $display("FAIL abort partial_results: got pf=%h fc=%0d ef=%b want pf=%h fc=%0d ef=%b",
                     path_fail, fail_count, error_flag, e.pf, e.fc, e.ef);
        end
        done_seen = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (done === 1'b1 || aborted === 1'b1 || busy === 1'b1) done_seen++;
        end
        vectors++;
        if (done_seen != 0) begin
            miscompares++;
            $display("FAIL abort quiet_after: got %0d active cycles want 0", done_seen);
        end
        vectors++;
        if (path_fail !== e.pf || fail_count !== e.fc) begin
            miscompares++;
            $display("FAIL abort retained: got pf=%h fc=%0d want pf=%h fc=%0d", path_fail, fail_count, e.pf, e.fc);
        end
        // abort alone and start+abort in IDLE do nothing
        abort = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        vectors++;
        if (aborted !== 1'b0 || busy !== 1'b0 || path_fail !== e.pf) begin
            miscompares++;
            $display("FAIL abort_in_idle: got aborted=%b busy=%b pf=%h want 0 0 %h", aborted, busy, path_fail, e.pf);
        end
        mode = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if (path_fail !== '0 || fail_count !== 5'd0 || error_flag !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_clears: got pf=%h fc=%0d ef=%b busy=%b want 0 0 0 1",
                     path_fail, fail_count, error_flag, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if (aborted !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_rst_hold: got aborted=%b busy=%b want 1 0", aborted, busy);
        end
        step();
    endtask

    task automatic test_reset_mid();
        mode = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            start = (i == 180);
            step();
        end
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || rst_c !== 1'b1 || mux_decoder_input !== 5'd1) begin
            miscompares++;
            $display("FAIL reset_mid precondition: got busy=%b rst_c=%b path=%0d want 1 1 1",
                     busy, rst_c, mux_decoder_input);
        end
        #2;
        reset = 1'b1;
        #1;
        rst_vec_obs = {busy, done, aborted, rst_c, K, mux_decoder_input, clock_mux_sel, mode_mux_sel,
                       sel_chain_input, sel_chain_output, bist_decoder_input, path_fail, fail_count, error_flag};
        vectors++;
        if (rst_vec_obs !== rst_vec_exp) begin
            miscompares++;
            $display("FAIL reset_mid values: got %h want %h", rst_vec_obs, rst_vec_exp);
        end
        @(negedge clock);
        reset = 1'b0;
        step();
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid stays_idle: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        rst_vec_exp = {1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 5'd0, 1'b0, 1'b0,
                       1'b0, 1'b1, 3'd6, 21'd0, 5'd0, 1'b0};
        test_reset();
        test_stuck_high();
        test_single_point();
        test_two_paths();
        test_window_edges();
        test_abort();
        test_busy_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
